// File: rtl/pool_row_packer.sv
// pool_row_packer
//   Takes the 1-bit stream from the binary 2x2 max-pooling stage, one bit per
//   input pixel strobe. Keeps only the stride-2 window results (odd row, odd
//   column) and packs each pooled row into a W/2-bit word. Words are handed
//   downstream through a 2-entry valid/ready FIFO.
//
// Ports
//   iCLK        clock, all logic on the rising edge
//   iRST        synchronous active-high reset
//   iCLR        synchronous frame restart (same clearing as iRST)
//   iEN         pixel strobe from the pooling stage
//   iDATA       pooled bit, valid while iEN=1
//   iREADY      downstream ready
//   oVALID      head word of the FIFO is available
//   oDATA       packed pooled row; the first kept column is in the MSB
//   oROW        pooled row index of oDATA (0..H/2-1)
//   oOVF        sticky: a row word was dropped because the FIFO was full
//   oBUSY       frame in progress
//   oFRAME_DONE one-cycle pulse after the last pixel of the frame
module pool_row_packer #(
  parameter int W    = 30,
  parameter int H    = 30,
  parameter int SKIP = 1,
  parameter int CW   = 5,
  parameter int RW   = 5
) (
  input  logic          iCLK,
  input  logic          iRST,
  input  logic          iCLR,
  input  logic          iEN,
  input  logic          iDATA,
  input  logic          iREADY,
  output logic          oVALID,
  output logic [W/2-1:0] oDATA,
  output logic [RW-2:0] oROW,
  output logic          oOVF,
  output logic          oBUSY,
  output logic          oFRAME_DONE
);

  localparam int PW  = W / 2;
  localparam int SKW = (SKIP > 0) ? $clog2(SKIP + 1) : 1;

  logic           clr;

  logic [SKW-1:0] skip_p0;
  logic [CW-1:0]  col_p0;
  logic [RW-1:0]  row_p0;
  logic           done_p0;
  logic           fdone_p1;
  logic [PW-1:0]  pack_p0;

  logic           skipping;
  logic           act;
  logic           colLast;
  logic           rowLast;
  logic           keep;
  logic           push;
  logic [PW-1:0]  word_p0;
  logic [RW-2:0]  rowIdx_p0;

  logic [PW-1:0]  memData_p1 [0:1];
  logic [RW-2:0]  memRow_p1  [0:1];
  logic           wrPtr_p1;
  logic           rdPtr_p1;
  logic [1:0]     cnt_p1;
  logic           vld_p1;
  logic           ovf_p1;
  logic           full;
  logic           pop;
  logic           wr;
  logic           drop;

  assign clr      = iRST | iCLR;
  assign skipping = iEN & ~clr & ~done_p0 & (skip_p0 != '0);
  assign act      = iEN & ~clr & ~done_p0 & (skip_p0 == '0);
  assign colLast  = (col_p0 == CW'(W - 1));
  assign rowLast  = (row_p0 == RW'(H - 1));
  assign keep     = act & row_p0[0] & col_p0[0];
  assign push     = act & row_p0[0] & colLast;
  // The pushed word already contains the current (last) kept bit.
  assign word_p0   = {pack_p0[PW-2:0], iDATA};
  assign rowIdx_p0 = row_p0[RW-1:1];

  // ---- stage p0: skip / pixel counters and row packer ----
  always_ff @(posedge iCLK) begin
    if (clr) begin
      skip_p0  <= SKW'(SKIP);
      col_p0   <= '0;
      row_p0   <= '0;
      done_p0  <= 1'b0;
      fdone_p1 <= 1'b0;
    end else begin
      fdone_p1 <= 1'b0;
      if (skipping) begin
        skip_p0 <= skip_p0 - SKW'(1);
      end else if (act) begin
        if (colLast) begin
          col_p0 <= '0;
          if (rowLast) begin
            done_p0  <= 1'b1;
            fdone_p1 <= 1'b1;
          end else begin
            row_p0 <= row_p0 + RW'(1);
          end
        end else begin
          col_p0 <= col_p0 + CW'(1);
        end
      end
    end
  end

  // Every odd row shifts in exactly PW bits, so the packer never needs clearing.
  always_ff @(posedge iCLK) begin
    if (keep) begin
      pack_p0 <= word_p0;
    end
  end

  // ---- stage p1: 2-entry output FIFO ----
  assign vld_p1 = (cnt_p1 != 2'd0);
  assign full   = (cnt_p1 == 2'd2);
  assign pop    = vld_p1 & iREADY & ~clr;
  // When full, a simultaneous pop frees the head slot, which is exactly the
  // slot wrPtr points to.
  assign wr     = push & (~full | pop);
  assign drop   = push & full & ~pop;

  always_ff @(posedge iCLK) begin
    if (clr) begin
      cnt_p1   <= 2'd0;
      wrPtr_p1 <= 1'b0;
      rdPtr_p1 <= 1'b0;
      ovf_p1   <= 1'b0;
    end else begin
      if (wr) begin
        wrPtr_p1 <= ~wrPtr_p1;
      end
      if (pop) begin
        rdPtr_p1 <= ~rdPtr_p1;
      end
      case ({wr, pop})
        2'b10:   cnt_p1 <= cnt_p1 + 2'd1;
        2'b01:   cnt_p1 <= cnt_p1 - 2'd1;
        default: cnt_p1 <= cnt_p1;
      endcase
      if (drop) begin
        ovf_p1 <= 1'b1;
      end
    end
  end

  always_ff @(posedge iCLK) begin
    if (wr) begin
      memData_p1[wrPtr_p1] <= word_p0;
      memRow_p1[wrPtr_p1]  <= rowIdx_p0;
    end
  end

  // Storage is not reset, so the outputs read as zero while the FIFO is empty.
  assign oVALID      = vld_p1;
  assign oDATA       = vld_p1 ? memData_p1[rdPtr_p1] : '0;
  assign oROW        = vld_p1 ? memRow_p1[rdPtr_p1] : '0;
  assign oOVF        = ovf_p1;
  assign oBUSY       = ~done_p0;
  assign oFRAME_DONE = fdone_p1;

endmodule

// File: tb/tb_pool_row_packer.sv
// tb_pool_row_packer
//   Directed bench for pool_row_packer (W=H=30, SKIP=1). Constant-pattern
//   frames come from a table with hand-computed words; random frames and the
//   FIFO/overflow/restart corner cases use a small image-to-word model.
module tb_pool_row_packer;

  localparam int W    = 30;
  localparam int H    = 30;
  localparam int SKIP = 1;
  localparam int NSTR = SKIP + W * H;

  logic        clk;
  logic        iRST;
  logic        iCLR;
  logic        iEN;
  logic        iDATA;
  logic        iREADY;
  logic        oVALID;
  logic [14:0] oDATA;
  logic [3:0]  oROW;
  logic        oOVF;
  logic        oBUSY;
  logic        oFRAME_DONE;

  pool_row_packer #(.W(W), .H(H), .SKIP(SKIP), .CW(5), .RW(5)) dut (
    .iCLK(clk), .iRST(iRST), .iCLR(iCLR), .iEN(iEN), .iDATA(iDATA),
    .iREADY(iREADY), .oVALID(oVALID), .oDATA(oDATA), .oROW(oROW),
    .oOVF(oOVF), .oBUSY(oBUSY), .oFRAME_DONE(oFRAME_DONE)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [14:0] d;
    logic [3:0]  r;
  } rec_t;

  typedef struct {
    string       name;
    int          mode;
    bit          gaps;
    logic [14:0] expWord;
  } vec_t;

  rec_t got[$];
  int   fdCount;
  int   nChecks;
  int   nFail;
  logic img [0:H-1][0:W-1];
  vec_t vecs [0:4];

  // Transfers are recorded at the falling edge, with the inputs that the
  // next rising edge will sample.
  always @(negedge clk) begin
    if (!iRST && !iCLR && oVALID && iREADY) begin
      got.push_back('{d: oDATA, r: oROW});
    end
    if (oFRAME_DONE) fdCount++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic fill_img(input int mode);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        case (mode)
          0: img[r][c] = 1'b1;
          1: img[r][c] = (r % 2 == 1) && (c == 1);
          2: img[r][c] = (r % 2 == 1) && (c == 29);
          3: img[r][c] = 1'b0;
          5: img[r][c] = (r % 2 == 0) || (c % 2 == 0);
          default: img[r][c] = 1'($urandom_range(0, 1));
        endcase
      end
    end
  endtask

  function automatic logic [14:0] model_word(input int r2);
    logic [14:0] w;
    w = '0;
    for (int j = 0; j < 15; j++) w[14-j] = img[2*r2+1][2*j+1];
    return w;
  endfunction

  // Strobe k (0-based) carries a skip bit for k<SKIP, else pixel k-SKIP.
  task automatic drive_pixels(input int k0, input int k1, input bit gaps);
    int p;
    for (int k = k0; k <= k1; k++) begin
      if (gaps) idle($urandom_range(0, 2));
      p = k - SKIP;
      iEN   = 1'b1;
      iDATA = (k < SKIP) ? 1'b1 : img[p / W][p % W];
      @(posedge clk);
      #1;
      iEN   = 1'b0;
      iDATA = 1'b0;
    end
  endtask

  task automatic do_clear();
    iCLR = 1'b1;
    @(posedge clk);
    #1;
    iCLR = 1'b0;
  endtask

  // Whole frame with frame-done timing checks; extra strobes after the end
  // must be ignored.
  task automatic full_frame(input string name, input bit gaps);
    fdCount = 0;
    drive_pixels(0, NSTR - 1, gaps);
    chk({name, " fdone pulse"}, 32'(oFRAME_DONE), 32'd1);
    chk({name, " busy after end"}, 32'(oBUSY), 32'd0);
    idle(1);
    chk({name, " fdone one cycle"}, 32'(oFRAME_DONE), 32'd0);
    drive_pixels(SKIP, SKIP + 3, 1'b0);
    idle(5);
    chk({name, " fdone count"}, 32'(fdCount), 32'd1);
    chk({name, " busy stays low"}, 32'(oBUSY), 32'd0);
  endtask

  task automatic check_words(input string name, input int n, input bit useConst,
                             input logic [14:0] cw);
    logic [14:0] e;
    chk({name, " word count"}, 32'(got.size()), 32'(n));
    for (int i = 0; i < n && i < got.size(); i++) begin
      e = useConst ? cw : model_word(i);
      chk($sformatf("%s word %0d", name, i), 32'(got[i].d), 32'(e));
      chk($sformatf("%s row %0d", name, i), 32'(got[i].r), 32'(i));
    end
  endtask

  initial begin
    nChecks = 0;
    nFail   = 0;
    fdCount = 0;
    iRST = 1'b1; iCLR = 1'b0; iEN = 1'b0; iDATA = 1'b0; iREADY = 1'b1;

    vecs[0] = '{"ones",     0, 1'b0, 15'h7FFF};
    vecs[1] = '{"col1",     1, 1'b0, 15'h4000};
    vecs[2] = '{"col29",    2, 1'b1, 15'h0001};
    vecs[3] = '{"zeros",    3, 1'b0, 15'h0000};
    vecs[4] = '{"evenonly", 5, 1'b0, 15'h0000};

    // Reset state
    idle(2);
    chk("rst valid", 32'(oVALID), 32'd0);
    chk("rst data",  32'(oDATA),  32'd0);
    chk("rst row",   32'(oROW),   32'd0);
    chk("rst ovf",   32'(oOVF),   32'd0);
    chk("rst busy",  32'(oBUSY),  32'd1);
    chk("rst fdone", 32'(oFRAME_DONE), 32'd0);
    iRST = 1'b0;

    // Constant-pattern frames from the table
    for (int v = 0; v < 5; v++) begin
      do_clear();
      got.delete();
      iREADY = 1'b1;
      fill_img(vecs[v].mode);
      full_frame(vecs[v].name, vecs[v].gaps);
      check_words(vecs[v].name, 15, 1'b1, vecs[v].expWord);
      chk({vecs[v].name, " ovf"}, 32'(oOVF), 32'd0);
    end

    // Random data with random strobe gaps
    do_clear();
    got.delete();
    fill_img(4);
    full_frame("rand", 1'b1);
    check_words("rand", 15, 1'b0, 15'h0);

    // Ready held low: FIFO fills, third row push overflows
    do_clear();
    got.delete();
    iREADY = 1'b0;
    fill_img(4);
    drive_pixels(0, 179, 1'b0);
    chk("full ovf before", 32'(oOVF), 32'd0);
    chk("full valid", 32'(oVALID), 32'd1);
    chk("full head data", 32'(oDATA), 32'(model_word(0)));
    chk("full head row", 32'(oROW), 32'd0);
    drive_pixels(180, 180, 1'b0);
    chk("ovf on third push", 32'(oOVF), 32'd1);
    drive_pixels(181, NSTR - 1, 1'b0);
    chk("ovf sticky", 32'(oOVF), 32'd1);
    chk("held data stable", 32'(oDATA), 32'(model_word(0)));
    chk("held row stable", 32'(oROW), 32'd0);
    iREADY = 1'b1;
    idle(5);
    check_words("drain", 2, 1'b0, 15'h0);
    chk("drained empty", 32'(oVALID), 32'd0);

    // Pop coinciding with a push while full: no overflow
    do_clear();
    got.delete();
    iREADY = 1'b0;
    fill_img(4);
    drive_pixels(0, 179, 1'b0);
    iREADY = 1'b1;
    drive_pixels(180, 180, 1'b0);
    iREADY = 1'b0;
    chk("pushpop ovf", 32'(oOVF), 32'd0);
    chk("pushpop popped", 32'(got.size()), 32'd1);
    iREADY = 1'b1;
    drive_pixels(181, NSTR - 1, 1'b0);
    idle(5);
    chk("pushpop ovf end", 32'(oOVF), 32'd0);
    check_words("pushpop", 15, 1'b0, 15'h0);

    // Restart in the middle of row 10 with a word on oVALID
    do_clear();
    got.delete();
    iREADY = 1'b0;
    fill_img(4);
    drive_pixels(0, SKIP + 10 * W + 5, 1'b0);
    chk("pre-clr valid", 32'(oVALID), 32'd1);
    chk("pre-clr ovf", 32'(oOVF), 32'd1);
    iCLR   = 1'b1;
    iREADY = 1'b1;
    @(posedge clk);
    #1;
    iCLR = 1'b0;
    chk("clr valid", 32'(oVALID), 32'd0);
    chk("clr ovf", 32'(oOVF), 32'd0);
    chk("clr busy", 32'(oBUSY), 32'd1);
    chk("clr no transfer", 32'(got.size()), 32'd0);
    fill_img(4);
    full_frame("afterclr", 1'b0);
    check_words("afterclr", 15, 1'b0, 15'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
